wptr_full: RTL
==============

WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 Parameter ADDRSIZE, default 4, SHALL set the address width; depth is 2^ADDRSIZE and ADDRSIZE >= 2.
REQ-002 Parameter AF_MARGIN, default 2, SHALL set the almost-full margin in entries; legal range is 1..2^ADDRSIZE-1.
REQ-003 wclk  input  1  SHALL be the write-domain clock; all state is rising-edge triggered.
REQ-004 wrst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 win  input  1  SHALL be the write request.
REQ-006 wclr_ovf  input  1  SHALL clear the sticky overflow flag.
REQ-007 wq2_rptr  input  ADDRSIZE+1  SHALL carry the Gray read pointer already synchronised into wclk.
REQ-008 wptr  output  ADDRSIZE+1  SHALL be the registered Gray write pointer, for synchronisation into the read domain.
REQ-009 waddr  output  ADDRSIZE  SHALL be the RAM write address, equal to the low ADDRSIZE bits of the binary write counter.
REQ-010 wfull  output  1  SHALL be the registered full flag.
REQ-011 walmost_full  output  1  SHALL be the registered almost-full flag.
REQ-012 wlevel  output  ADDRSIZE+1  SHALL be the registered write-side fill level, range 0..2^ADDRSIZE.
REQ-013 woverflow  output  1  SHALL be a sticky flag that records a write attempted while full.

Function
REQ-014 Internal binary counter wbin SHALL be ADDRSIZE+1 bits.
REQ-015 wbnext SHALL equal wbin + (win & ~wfull), modulo 2^(ADDRSIZE+1).
REQ-016 wgnext SHALL equal (wbnext >> 1) ^ wbnext.
REQ-017 Each edge SHALL load wbin <= wbnext and wptr <= wgnext; the pointer never advances while wfull=1.
REQ-018 wfull SHALL load (wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}) each edge.
REQ-019 rbin_sync SHALL be the Gray-to-binary conversion of wq2_rptr; it is combinational.
REQ-020 wlevel SHALL load (wbnext - rbin_sync) modulo 2^(ADDRSIZE+1) each edge.
REQ-021 walmost_full SHALL load (next level >= 2^ADDRSIZE - AF_MARGIN) each edge.
REQ-022 woverflow SHALL set on an edge where win=1 and wfull=1.
REQ-023 woverflow SHALL clear on an edge where wclr_ovf=1 and no set condition is present; set wins when both occur.
REQ-024 A write accepted on edge N SHALL be reflected in wptr, wlevel, wfull and walmost_full at edge N; latency is one cycle.
REQ-025 A read-pointer change on wq2_rptr SHALL be able to deassert wfull only at the next edge; full is pessimistic, never optimistic.
REQ-026 Wrap-around: wbin SHALL roll from 2^(ADDRSIZE+1)-1 to 0, and waddr from 2^ADDRSIZE-1 to 0, with no discontinuity in the Gray sequence.
REQ-027 Simultaneous win with a full-clearing read-pointer update SHALL NOT be accepted on that edge, because the registered wfull governs.

Reset
REQ-028 While wrst_n=0, the block SHALL force wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0 and woverflow=0 immediately, regardless of wclk.
REQ-029 Reset asserted mid-operation SHALL discard all state; after deassertion the first write SHALL land at waddr=0.
REQ-030 Reset deassertion SHALL be used synchronously to wclk; reset synchronisation is external to this block.

Structure
REQ-031 Package fifo_pkg SHALL hold the default ADDRSIZE, the default AF_MARGIN, and the bin2gray/gray2bin functions.
REQ-032 Gray-to-binary conversion SHALL be one sub-module, gray2bin, parameterised by width (ADDRSIZE+1) and purely combinational.
REQ-033 No RAM and no synchroniser flops SHALL reside in wptr_full.

Verification (ADDRSIZE=4, AF_MARGIN=2, wq2_rptr held 0 unless stated)
REQ-034 Reset: assert wrst_n=0 mid-stream with wbin=7 -> all outputs 0 without a clock edge; next accepted write -> waddr=0.
REQ-035 Fill: 16 consecutive win=1 cycles -> wptr sequence 00001,00011,00010,...; wlevel=16 and wfull=1 after the 16th edge.
REQ-036 Overflow on full: 17th write -> wptr, waddr and wlevel unchanged, woverflow=1.
REQ-037 Almost-full: walmost_full rises on the edge where wlevel becomes 14 and stays 0 at level 13.
REQ-038 Full clears on read: with the block full, set wq2_rptr=00001 -> wfull=0 and wlevel=15 one edge later.
REQ-039 Wrap: with wq2_rptr=11000 (binary 16), write 32 entries total -> waddr wraps 15->0, wbin=0, wptr=00000, wfull=1.
REQ-040 Set/clear priority: win=1 and wclr_ovf=1 on the same edge while full -> woverflow stays 1; wclr_ovf alone -> woverflow 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO pointer defaults and Gray code helpers
package fifo_pkg;

  localparam int DEF_ADDRSIZE  = 4;
  localparam int DEF_AF_MARGIN = 2;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int i = 0; i < 32; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// rtl/gray2bin.sv - combinational Gray-to-binary converter
// Each binary bit is the XOR of its Gray bit and every Gray bit above it.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full.sv
// rtl/wptr_full.sv - async FIFO write pointer, full/almost-full, level and overflow
// Full is computed from the registered pointer's next value against the synchronised read pointer.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE  = DEF_ADDRSIZE,
  parameter int AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                win,
  input  logic                wclr_ovf,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam logic [ADDRSIZE:0] AF_THRESH = (ADDRSIZE+1)'((1 << ADDRSIZE) - AF_MARGIN);

  logic [ADDRSIZE:0] r_wbin;
  logic [ADDRSIZE:0] r_wptr;
  logic              r_wfull;
  logic              r_walmost_full;
  logic [ADDRSIZE:0] r_wlevel;
  logic              r_woverflow;

  logic [ADDRSIZE:0] w_wbnext;
  logic [ADDRSIZE:0] w_wgnext;
  logic [ADDRSIZE:0] w_rbin_sync;
  logic [ADDRSIZE:0] w_level_next;
  logic              w_full_next;
  logic              w_inc;

  gray2bin #(.WIDTH(ADDRSIZE+1)) u_rptr_g2b (
    .i_gray (wq2_rptr),
    .o_bin  (w_rbin_sync)
  );

  // Registered full gates the increment, so a same-cycle read release cannot admit a write.
  assign w_inc        = win & ~r_wfull;
  assign w_wbnext     = r_wbin + {{ADDRSIZE{1'b0}}, w_inc};
  assign w_wgnext     = (w_wbnext >> 1) ^ w_wbnext;
  assign w_full_next  = (w_wgnext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
  assign w_level_next = w_wbnext - w_rbin_sync;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr         <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wlevel       <= '0;
      r_woverflow    <= 1'b0;
    end else begin
      r_wbin         <= w_wbnext;
      r_wptr         <= w_wgnext;
      r_wfull        <= w_full_next;
      r_walmost_full <= (w_level_next >= AF_THRESH);
      r_wlevel       <= w_level_next;
      if (win && r_wfull) begin
        r_woverflow <= 1'b1;
      end else if (wclr_ovf) begin
        r_woverflow <= 1'b0;
      end
    end
  end

  assign wptr         = r_wptr;
  assign waddr        = r_wbin[ADDRSIZE-1:0];
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wlevel       = r_wlevel;
  assign woverflow    = r_woverflow;

endmodule
